// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [15:0] seg_word_t;

  typedef enum logic {OWN_CPU, OWN_DBG} arb_owner_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to segment pattern, bit order {dp,g,f,e,d,c,b,a}, 1 = lit.
module seg_hex_decode (
  input  logic [3:0] i_num,
  output logic [7:0] o_light
);

  always_comb begin
    o_light = 8'h00;
    case (i_num)
      4'h0: o_light = 8'h3F;
      4'h1: o_light = 8'h06;
      4'h2: o_light = 8'h5B;
      4'h3: o_light = 8'h4F;
      4'h4: o_light = 8'h66;
      4'h5: o_light = 8'h6D;
      4'h6: o_light = 8'h7D;
      4'h7: o_light = 8'h07;
      4'h8: o_light = 8'h7F;
      4'h9: o_light = 8'h6F;
      4'hA: o_light = 8'h77;
      4'hB: o_light = 8'h7C;
      4'hC: o_light = 8'h39;
      4'hD: o_light = 8'h5E;
      4'hE: o_light = 8'h79;
      4'hF: o_light = 8'h71;
      default: o_light = 8'h00;
    endcase
  end

endmodule

// File: rtl/seg_scan_sched.sv
// 4-digit display scan scheduler with round-robin CPU/debug write arbitration and frame-boundary commit.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_sched
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 2000,
  parameter int GUARD    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  seg_word_t             cpu_data,
  output logic                  cpu_gnt,
  input  logic                  dbg_req,
  input  seg_word_t             dbg_data,
  output logic                  dbg_gnt,
  output logic [NUM_DIGITS-1:0] ena,
  output logic [3:0]            num,
  output logic [7:0]            light,
  output logic                  frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_dig;
  seg_word_t     r_active;
  seg_word_t     r_shadow;
  logic          r_dirty;
  arb_owner_t    r_pri;
  logic          r_cpu_gnt;
  logic          r_dbg_gnt;
  logic          r_frame_done;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_gap;
  logic                  w_grant_cpu;
  logic                  w_grant_dbg;
  seg_word_t             w_wr_data;
  logic                  w_guard;
  logic [NUM_DIGITS-1:0] w_blank;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_dig == 2'd3);

  // A grant pulse blocks sampling for one edge so the winner can drop its request.
  assign w_gap       = r_cpu_gnt | r_dbg_gnt;
  assign w_grant_cpu = !w_gap && cpu_req && (!dbg_req || (r_pri == OWN_CPU));
  assign w_grant_dbg = !w_gap && dbg_req && (!cpu_req || (r_pri == OWN_DBG));
  assign w_wr_data   = w_grant_cpu ? cpu_data : dbg_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_dig <= 2'd0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_dig <= r_dig + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pri     <= OWN_CPU;
      r_cpu_gnt <= 1'b0;
      r_dbg_gnt <= 1'b0;
    end else begin
      r_cpu_gnt <= w_grant_cpu;
      r_dbg_gnt <= w_grant_dbg;
      if (w_grant_cpu) begin
        r_pri <= OWN_DBG;
      end else if (w_grant_dbg) begin
        r_pri <= OWN_CPU;
      end
    end
  end

  // A write landing on the commit edge goes to shadow and stays dirty for the next frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active     <= '0;
      r_shadow     <= '0;
      r_dirty      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_frame_end && r_dirty) begin
        r_active <= r_shadow;
        r_dirty  <= 1'b0;
      end
      if (w_grant_cpu || w_grant_dbg) begin
        r_shadow <= w_wr_data;
        r_dirty  <= 1'b1;
      end
    end
  end

`ifdef SEG_LZ_BLANK_EN
  assign w_blank[3] = (r_active[15:12] == 4'h0);
  assign w_blank[2] = w_blank[3] && (r_active[11:8] == 4'h0);
  assign w_blank[1] = w_blank[2] && (r_active[7:4] == 4'h0);
  assign w_blank[0] = 1'b0;
`else
  assign w_blank = '0;
`endif

  assign w_guard = (r_cnt < GUARD_C);

  assign ena        = w_guard ? '0 : ((NUM_DIGITS'(1) << r_dig) & ~w_blank);
  assign num        = r_active[4*r_dig +: 4];
  assign cpu_gnt    = r_cpu_gnt;
  assign dbg_gnt    = r_dbg_gnt;
  assign frame_done = r_frame_done;

  seg_hex_decode u_decode (
    .i_num   (num),
    .o_light (light)
  );

endmodule

// File: tb/tb_seg_scan_sched.sv
// Self-checking bench for seg_scan_sched with a small scan configuration (SCAN_DIV=8, GUARD=2).
module tb_seg_scan_sched;
  import seg_pkg::*;

  localparam int SCAN_DIV = 8;
  localparam int GUARD    = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      cpu_req = 1'b0;
  seg_word_t cpu_data = '0;
  logic      cpu_gnt;
  logic      dbg_req = 1'b0;
  seg_word_t dbg_data = '0;
  logic      dbg_gnt;
  logic [3:0] ena;
  logic [3:0] num;
  logic [7:0] light;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  seg_word_t exp_q[$];
  seg_word_t cur_word = '0;

  seg_scan_sched #(.SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_data   (cpu_data),
    .cpu_gnt    (cpu_gnt),
    .dbg_req    (dbg_req),
    .dbg_data   (dbg_data),
    .dbg_gnt    (dbg_gnt),
    .ena        (ena),
    .num        (num),
    .light      (light),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
      4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
      4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
      4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
    endcase
  endfunction

  function automatic logic [3:0] exp_ena(input seg_word_t w, input int k);
    logic [3:0] e;
    e = 4'b0001 << k;
`ifdef SEG_LZ_BLANK_EN
    if (k == 3 && w[15:12] == 4'h0) e = 4'b0000;
    if (k == 2 && w[15:8]  == 8'h00) e = 4'b0000;
    if (k == 1 && w[15:4]  == 12'h000) e = 4'b0000;
`endif
    return e;
  endfunction

  task automatic wait_frame_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 40);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_done_timeout: no pulse within %0d cycles", n);
    end
  endtask

  // Pops the expected word and checks the whole frame starting at the current (frame_done) sample.
  task automatic scoreboard_frame();
    seg_word_t w;
    int k, c;
    logic [3:0] nib, e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: no expected frame queued");
      w = cur_word;
    end else begin
      w = exp_q.pop_front();
    end
    cur_word = w;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      k   = i / SCAN_DIV;
      c   = i % SCAN_DIV;
      nib = w[4*k +: 4];
      e   = (c < GUARD) ? 4'b0000 : exp_ena(w, k);
      checks++;
      if (ena !== e) begin
        errors++;
        $display("FAIL sb_ena: word=%h slot=%0d cyc=%0d got=%b exp=%b", w, k, c, ena, e);
      end
      checks++;
      if (num !== nib) begin
        errors++;
        $display("FAIL sb_num: word=%h slot=%0d cyc=%0d got=%h exp=%h", w, k, c, num, nib);
      end
      checks++;
      if (frame_done !== (i == 0)) begin
        errors++;
        $display("FAIL sb_frame_done: idx=%0d got=%b exp=%b", i, frame_done, (i == 0));
      end
      if (c == 4) begin
        checks++;
        if (light !== seg_of(nib)) begin
          errors++;
          $display("FAIL sb_light: slot=%0d got=%h exp=%h", k, light, seg_of(nib));
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] e;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ena, num, cpu_gnt, dbg_gnt, frame_done} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: ena=%b num=%h cg=%b dg=%b fd=%b exp all zero", ena, num, cpu_gnt, dbg_gnt, frame_done);
    end
    checks++;
    if (light !== 8'h3F) begin
      errors++;
      $display("FAIL reset_light: got=%h exp=3f", light);
    end
    rst = 1'b1;
    for (int i = 0; i < SCAN_DIV; i++) begin
      if (i > 0) @(negedge clk);
      e = (i < GUARD) ? 4'b0000 : 4'b0001;
      checks++;
      if (ena !== e) begin
        errors++;
        $display("FAIL reset_release_ena: cyc=%0d got=%b exp=%b", i, ena, e);
      end
    end
  endtask

  task automatic test_cpu_write();
    wait_frame_done();
    cpu_req = 1'b1;
    cpu_data = 16'h1234;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      errors++;
      $display("FAIL cpu_gnt_latency: cg=%b dg=%b exp cg=1 dg=0", cpu_gnt, dbg_gnt);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL cpu_gnt_pulse: got=%b exp=0", cpu_gnt);
    end
    exp_q.push_back(16'h1234);
    for (int i = 2; i < FRAME; i++) begin
      checks++;
      if (num !== 4'h0) begin
        errors++;
        $display("FAIL cpu_not_early: idx=%0d num=%h exp=0", i, num);
      end
      @(negedge clk);
    end
    scoreboard_frame();
  endtask

  task automatic test_reset_mid_slot();
    wait_frame_done();
    repeat (20) @(negedge clk);
    checks++;
    if (ena !== 4'b0100 || num !== 4'h2) begin
      errors++;
      $display("FAIL mid_slot_pre: ena=%b num=%h exp ena=0100 num=2", ena, num);
    end
    cpu_req = 1'b1;
    cpu_data = 16'h9999;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_grant_pre: cg=%b exp=1", cpu_gnt);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ena, num, cpu_gnt, dbg_gnt, frame_done} !== 11'b0) begin
      errors++;
      $display("FAIL mid_reset_async: ena=%b num=%h cg=%b dg=%b fd=%b exp all zero", ena, num, cpu_gnt, dbg_gnt, frame_done);
    end
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < SCAN_DIV; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (ena !== ((i < GUARD) ? 4'b0000 : 4'b0001) || num !== 4'h0) begin
        errors++;
        $display("FAIL mid_release: cyc=%0d ena=%b num=%h", i, ena, num);
      end
    end
    exp_q.push_back(16'h0000);
    wait_frame_done();
    scoreboard_frame();
  endtask

  task automatic test_contention();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cpu_req = 1'b1; cpu_data = 16'h5555;
    dbg_req = 1'b1; dbg_data = 16'hABCD;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      errors++;
      $display("FAIL cont_first: cg=%b dg=%b exp cg=1 dg=0", cpu_gnt, dbg_gnt);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin
      errors++;
      $display("FAIL cont_gap: cg=%b dg=%b exp both 0", cpu_gnt, dbg_gnt);
    end
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL cont_second: cg=%b dg=%b exp cg=0 dg=1", cpu_gnt, dbg_gnt);
    end
    dbg_req = 1'b0;
    exp_q.push_back(16'hABCD);
    wait_frame_done();
    scoreboard_frame();
  endtask

  task automatic test_round_robin();
    wait_frame_done();
    cpu_req = 1'b1; cpu_data = 16'h0001;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rr_cpu_only: cg=%b exp=1", cpu_gnt);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_data = 16'h7777;
    dbg_req = 1'b1; dbg_data = 16'h0F0F;
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rr_dbg_wins: cg=%b dg=%b exp cg=0 dg=1", cpu_gnt, dbg_gnt);
    end
    dbg_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rr_gap: cg=%b dg=%b exp both 0", cpu_gnt, dbg_gnt);
    end
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rr_cpu_after: cg=%b exp=1", cpu_gnt);
    end
    cpu_req = 1'b0;
    exp_q.push_back(16'h7777);
    wait_frame_done();
    scoreboard_frame();
  endtask

  task automatic test_commit_edge();
    wait_frame_done();
    cpu_req = 1'b1; cpu_data = 16'h1111;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL ce_shadow_write: cg=%b exp=1", cpu_gnt);
    end
    cpu_req = 1'b0;
    for (int i = 2; i < FRAME; i++) @(negedge clk);
    dbg_req = 1'b1; dbg_data = 16'h2222;
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL ce_same_edge: dg=%b fd=%b exp both 1", dbg_gnt, frame_done);
    end
    dbg_req = 1'b0;
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    scoreboard_frame();
    wait_frame_done();
    scoreboard_frame();
  endtask

  task automatic test_lz_blank();
    wait_frame_done();
    cpu_req = 1'b1; cpu_data = 16'h0050;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL lz_write: cg=%b exp=1", cpu_gnt);
    end
    cpu_req = 1'b0;
    exp_q.push_back(16'h0050);
    wait_frame_done();
    scoreboard_frame();
  endtask

  task automatic test_wrap();
    int n;
    logic [3:0] e;
    wait_frame_done();
    for (int f = 0; f < 10; f++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n < FRAME && (n % SCAN_DIV) == 3) begin
          e = exp_ena(cur_word, n / SCAN_DIV);
          checks++;
          if (ena !== e) begin
            errors++;
            $display("FAIL wrap_dig: frame=%0d slot=%0d got=%b exp=%b", f, n / SCAN_DIV, ena, e);
          end
        end
      end while (!frame_done && n < 40);
      checks++;
      if (n != FRAME) begin
        errors++;
        $display("FAIL wrap_period: frame=%0d got=%0d exp=%0d", f, n, FRAME);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_reset_mid_slot();
    test_contention();
    test_round_robin();
    test_commit_edge();
    test_lz_blank();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
